modulo_display_siete_segmentos_param: RTL

- Parametrised successor to the per-bit 0/1 seven-segment driver.
- Captures an ANCHO-bit value on a load strobe and renders it on NUM_DIGITOS active-low displays.
- Four modes: per-bit binary, hexadecimal, decimal (sequential shift-add-3 BCD conversion) and blank.
- Adds registered outputs, busy/done handshake, leading-zero suppression, overflow indication and blinking.
- Sits between the counter/datapath and the board HEX pins.

---
 rtl/modulo_display_siete_segmentos_param.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/modulo_display_siete_segmentos_param.sv
// Seven-segment display driver for NUM_DIGITOS active-low digits. It shows a captured ANCHO-bit value
// in binary, hex or decimal, or blanks the digits. Outputs are registered and can be made to blink.
module modulo_display_siete_segmentos_param #(
    parameter int ANCHO        = 6,
    parameter int NUM_DIGITOS  = 6,
    parameter int DIV_PARPADEO = 25000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cargar,
    input  logic [ANCHO-1:0]         valor,
    input  logic [1:0]               modo,
    input  logic                     supresion_ceros,
    input  logic                     parpadeo,
    output logic                     ocupado,
    output logic                     listo,
    output logic [7*NUM_DIGITOS-1:0] segmentos
);

    // ceil(ANCHO*log10(2)) decimal digits, using log10(2) ~= 0.30103
    localparam int BCD_DIG = (ANCHO * 30103 + 99999) / 100000;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int EXT_W   = ANCHO + BCD_W + 4 * NUM_DIGITOS;
    localparam int CNT_W   = $clog2(ANCHO + 1);
    localparam int BLK_W   = (DIV_PARPADEO > 1) ? $clog2(DIV_PARPADEO) : 1;

    localparam logic [6:0] BLANCO = 7'b1111111;
    localparam logic [6:0] GUION  = 7'b0111111;

    typedef enum logic [1:0] {REPOSO, CONVERTIR, ACTUALIZAR} estado_t;

    estado_t                  estado_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [ANCHO-1:0]         val_q;
    logic [ANCHO-1:0]         sh_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [1:0]               modo_q;
    logic                     supr_q;
    logic [7*NUM_DIGITOS-1:0] seg_q;
    logic [7*NUM_DIGITOS-1:0] pat_d;
    logic                     listo_q;
    logic [BLK_W-1:0]         blk_q;
    logic                     fase_q;

    logic [EXT_W-1:0] ext_val;
    logic [EXT_W-1:0] ext_bcd;
    logic [EXT_W-1:0] src;
    logic [3:0]       dig;
    logic             ovf;
    logic             visto;

    function automatic logic [6:0] glifo(input logic [3:0] d);
        case (d)
            4'h0: glifo = 7'b1000000;
            4'h1: glifo = 7'b1111001;
            4'h2: glifo = 7'b0100100;
            4'h3: glifo = 7'b0110000;
            4'h4: glifo = 7'b0011001;
            4'h5: glifo = 7'b0010010;
            4'h6: glifo = 7'b0000010;
            4'h7: glifo = 7'b1111000;
            4'h8: glifo = 7'b0000000;
            4'h9: glifo = 7'b0010000;
            4'hA: glifo = 7'b0001000;
            4'hB: glifo = 7'b0000011;
            4'hC: glifo = 7'b1000110;
            4'hD: glifo = 7'b0100001;
            4'hE: glifo = 7'b0000110;
            default: glifo = 7'b0001110;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] ajustar(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < BCD_DIG; d++) begin
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign ocupado   = (estado_q != REPOSO);
    assign listo     = listo_q;
    assign segmentos = seg_q | {7*NUM_DIGITOS{parpadeo & fase_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            seg_q    <= '1;
            listo_q  <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (cargar) begin
                        cnt_q    <= '0;
                        estado_q <= (modo == 2'b10) ? CONVERTIR : ACTUALIZAR;
                    end
                end
                CONVERTIR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ANCHO - 1)) estado_q <= ACTUALIZAR;
                end
                ACTUALIZAR: begin
                    seg_q    <= pat_d;
                    listo_q  <= 1'b1;
                    estado_q <= REPOSO;
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    // Captured operands and the double-dabble shift register need no reset
    always_ff @(posedge clk) begin
        if (estado_q == REPOSO && cargar) begin
            val_q  <= valor;
            sh_q   <= valor;
            modo_q <= modo;
            supr_q <= supresion_ceros;
            bcd_q  <= '0;
        end else if (estado_q == CONVERTIR) begin
            {bcd_q, sh_q} <= {ajustar(bcd_q), sh_q} << 1;
        end
    end

    always_comb begin
        ext_val = EXT_W'(val_q);
        ext_bcd = EXT_W'(bcd_q);
        src     = ext_val;
        pat_d   = '1;
        ovf     = 1'b0;
        visto   = 1'b0;
        dig     = '0;
        case (modo_q)
            2'b00: begin
                ovf = |(ext_val >> NUM_DIGITOS);
                for (int i = 0; i < NUM_DIGITOS; i++) begin
                    if (i < ANCHO) pat_d[7*i +: 7] = glifo({3'b000, ext_val[i]});
                end
            end
            2'b01, 2'b10: begin
                src = (modo_q == 2'b01) ? ext_val : ext_bcd;
                ovf = |(src >> (4 * NUM_DIGITOS));
                // Scan from the top so zeros above the first nonzero digit can be blanked
                for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
                    dig = src[4*i +: 4];
                    if (dig != 4'd0 || i == 0) visto = 1'b1;
                    pat_d[7*i +: 7] = (supr_q && !visto) ? BLANCO : glifo(dig);
                end
            end
            default: ;
        endcase
        if (ovf) pat_d = {NUM_DIGITOS{GUION}};
    end

    // Blink timebase free-runs; fase_q=1 is the hidden half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q  <= '0;
            fase_q <= 1'b0;
        end else if (blk_q == BLK_W'(DIV_PARPADEO - 1)) begin
            blk_q  <= '0;
            fase_q <= ~fase_q;
        end else begin
            blk_q <= blk_q + 1'b1;
        end
    end

endmodule
